// File: rtl/data_mem_responder.sv
// data_mem_responder - load/store responder over an on-chip word array with fixed latency
//
// Ports:
//   clk, reset                 clock; asynchronous active-low reset
//   req_valid/req_ready        request handshake (ready only while idle)
//   req_write                  1 = store, 0 = load
//   req_addr                   byte address
//   req_wdata                  store data, right-aligned
//   req_size                   funct3 size code (B/H/W/BU/HU)
//   rsp_valid/rsp_ready        response handshake, held until taken
//   rsp_rdata                  load result (0 for stores and errors)
//   rsp_err                    misaligned, out-of-range or illegal size
module data_mem_responder #(
    parameter int ADDR_WIDTH   = 16,
    parameter int DEPTH_WORDS  = 1024,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    input  logic [2:0]            req_size,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err
);

    localparam int IDX_W  = ADDR_WIDTH - 2;
    localparam int MEM_AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] WAIT_LAST = 4'(READ_LATENCY - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t           state, state_next;
    logic [3:0]       cnt, cnt_next;
    logic [31:0]      mem [DEPTH_WORDS];

    logic [IDX_W-1:0] word_idx;
    logic [MEM_AW-1:0] mem_idx;
    logic [1:0]       lane;
    logic [31:0]      rd_word;
    logic [7:0]       rd_byte;
    logic [15:0]      rd_half;
    logic             accept, size_bad, align_bad, range_bad, acc_err, store_en;
    logic [3:0]       wr_be;
    logic [31:0]      wr_data, ld_result, acc_rdata;
    logic [31:0]      pend_rdata;
    logic             pend_err;

    assign req_ready = (state == S_IDLE);
    assign rsp_valid = (state == S_RESP);
    assign accept    = req_valid && req_ready;

    assign word_idx  = req_addr[ADDR_WIDTH-1:2];
    assign mem_idx   = word_idx[MEM_AW-1:0];
    assign lane      = req_addr[1:0];
    assign rd_word   = mem[mem_idx];
    assign rd_byte   = rd_word[{lane, 3'b000} +: 8];
    assign rd_half   = lane[1] ? rd_word[31:16] : rd_word[15:0];

    // Unsigned sizes are load-only; a store with BU/HU is rejected.
    always_comb begin
        size_bad = 1'b1;
        case (req_size)
            3'b000, 3'b001, 3'b010: size_bad = 1'b0;
            3'b100, 3'b101:         size_bad = req_write;
            default:                size_bad = 1'b1;
        endcase
    end

    assign align_bad = ((req_size[1:0] == 2'b01) && req_addr[0]) ||
                       ((req_size == 3'b010) && (lane != 2'b00));
    assign range_bad = ({{(32-IDX_W){1'b0}}, word_idx} >= 32'(DEPTH_WORDS));
    assign acc_err   = size_bad || align_bad || range_bad;
    // Errors never touch the array, so an out-of-range index that would alias
    // onto a real word is harmless.
    assign store_en  = accept && req_write && !acc_err;

    always_comb begin
        wr_be   = 4'b1111;
        wr_data = req_wdata;
        case (req_size[1:0])
            2'b00: begin
                wr_be   = 4'b0001 << lane;
                wr_data = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                wr_be   = lane[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{req_wdata[15:0]}};
            end
            default: begin
                wr_be   = 4'b1111;
                wr_data = req_wdata;
            end
        endcase
    end

    always_comb begin
        ld_result = 32'h0;
        case (req_size)
            3'b000:  ld_result = {{24{rd_byte[7]}}, rd_byte};
            3'b100:  ld_result = {24'h0, rd_byte};
            3'b001:  ld_result = {{16{rd_half[15]}}, rd_half};
            3'b101:  ld_result = {16'h0, rd_half};
            3'b010:  ld_result = rd_word;
            default: ld_result = 32'h0;
        endcase
    end

    assign acc_rdata = (acc_err || req_write) ? 32'h0 : ld_result;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    cnt_next   = 4'd0;
                    state_next = (READ_LATENCY > 1) ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                // cnt is the number of WAIT edges already taken; the edge
                // that sees WAIT_LAST is the READ_LATENCY-th after accept.
                if (cnt == WAIT_LAST) begin
                    state_next = S_RESP;
                end else begin
                    cnt_next = cnt + 4'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            cnt        <= 4'd0;
            pend_rdata <= 32'h0;
            pend_err   <= 1'b0;
            rsp_rdata  <= 32'h0;
            rsp_err    <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (accept) begin
                pend_rdata <= acc_rdata;
                pend_err   <= acc_err;
            end
            if ((state_next == S_RESP) && (state != S_RESP)) begin
                // With single-cycle latency the result goes straight out at accept.
                rsp_rdata <= (state == S_IDLE) ? acc_rdata : pend_rdata;
                rsp_err   <= (state == S_IDLE) ? acc_err   : pend_err;
            end else if ((state == S_RESP) && rsp_ready) begin
                rsp_rdata <= 32'h0;
                rsp_err   <= 1'b0;
            end
        end
    end

    // Array contents survive reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (store_en && wr_be[i]) begin
                mem[mem_idx][i*8 +: 8] <= wr_data[i*8 +: 8];
            end
        end
    end

endmodule
